// File: rtl/s2_window_streamer_if.sv
// Stream bundle between the S2 pooling stage, the window streamer and the C3 engine.
interface s2_window_streamer_if #(
  parameter int unsigned CH = 6,
  parameter int unsigned DW = 8
);
  logic              in_valid;
  logic [CH*DW-1:0]  in_data;
  logic              win_valid;
  logic              win_ready;
  logic [CH*DW-1:0]  win_data;
  logic              win_first;
  logic              win_last;
  logic              win_frame_last;
  logic [3:0]        win_oy;
  logic [3:0]        win_ox;

  modport master (
    input  in_valid, in_data, win_ready,
    output win_valid, win_data, win_first, win_last, win_frame_last, win_oy, win_ox
  );

  modport slave (
    output in_valid, in_data, win_ready,
    input  win_valid, win_data, win_first, win_last, win_frame_last, win_oy, win_ox
  );
endinterface

// File: rtl/s2_window_streamer.sv
// Ping-pong S2 frame store replaying each frame as KxK windows to the C3 engine.
module s2_window_streamer #(
  parameter int unsigned IN_W = 14,
  parameter int unsigned IN_H = 14,
  parameter int unsigned K    = 5,
  parameter int unsigned CH   = 6,
  parameter int unsigned DW   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  s2_window_streamer_if.master    bus,
  output logic [1:0]              bank_full,
  output logic                    overflow
);
  localparam int unsigned OUT_W = IN_W - K + 1;
  localparam int unsigned OUT_H = IN_H - K + 1;
  localparam int unsigned DEPTH = IN_W * IN_H;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned KW    = $clog2(K);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  logic [CH*DW-1:0] mem [2][DEPTH];

  // Write side
  logic          wr_bank;
  logic [AW-1:0] wr_cnt;
  logic          wr_accept;
  logic          wr_done;

  assign wr_accept = bus.in_valid && !bank_full[wr_bank];
  assign wr_done   = wr_accept && (wr_cnt == AW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank  <= 1'b0;
      wr_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      if (bus.in_valid && bank_full[wr_bank])
        overflow <= 1'b1;
      if (wr_accept) begin
        if (wr_done) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept)
      mem[wr_bank][wr_cnt] <= bus.in_data;
  end

  // Read side
  state_t        state, state_nxt;
  logic          rd_bank;
  logic [3:0]    oy, ox;
  logic [KW-1:0] ky, kx;
  logic          load;
  logic          rd_release;
  logic          kx_max, ky_max, ox_max, oy_max, at_end;
  logic [AW-1:0] rd_row, rd_col, rd_addr;

  assign kx_max = (kx == KW'(K - 1));
  assign ky_max = (ky == KW'(K - 1));
  assign ox_max = (ox == 4'(OUT_W - 1));
  assign oy_max = (oy == 4'(OUT_H - 1));
  assign at_end = kx_max && ky_max && ox_max && oy_max;

  always_comb begin
    rd_row  = AW'(oy) + AW'(ky);
    rd_col  = AW'(ox) + AW'(kx);
    rd_addr = rd_row * AW'(IN_W) + rd_col;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    rd_release = 1'b0;
    case (state)
      IDLE:   if (bank_full[rd_bank]) state_nxt = STREAM;
      STREAM: begin
        if (!bus.win_valid || bus.win_ready) begin
          load = 1'b1;
          if (at_end) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.win_valid && bus.win_ready) begin
          rd_release = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register and window counters; counters wrap to 0 on the final load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bank            <= 1'b0;
      oy                 <= '0;
      ox                 <= '0;
      ky                 <= '0;
      kx                 <= '0;
      bus.win_valid      <= 1'b0;
      bus.win_data       <= '0;
      bus.win_first      <= 1'b0;
      bus.win_last       <= 1'b0;
      bus.win_frame_last <= 1'b0;
      bus.win_oy         <= '0;
      bus.win_ox         <= '0;
    end else begin
      if (load) begin
        bus.win_valid      <= 1'b1;
        bus.win_data       <= mem[rd_bank][rd_addr];
        bus.win_first      <= (ky == '0) && (kx == '0);
        bus.win_last       <= kx_max && ky_max;
        bus.win_frame_last <= at_end;
        bus.win_oy         <= oy;
        bus.win_ox         <= ox;
        if (kx_max) begin
          kx <= '0;
          if (ky_max) begin
            ky <= '0;
            if (ox_max) begin
              ox <= '0;
              oy <= oy_max ? '0 : oy + 1'b1;
            end else begin
              ox <= ox + 1'b1;
            end
          end else begin
            ky <= ky + 1'b1;
          end
        end else begin
          kx <= kx + 1'b1;
        end
      end else if (state != STREAM && bus.win_ready) begin
        bus.win_valid <= 1'b0;
      end
      if (rd_release)
        rd_bank <= ~rd_bank;
    end
  end

  // Each flag is set only by the writer and cleared only by the reader
  logic [1:0] set_mask, clr_mask;
  assign set_mask = wr_done    ? (2'b01 << wr_bank) : 2'b00;
  assign clr_mask = rd_release ? (2'b01 << rd_bank) : 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) bank_full <= 2'b00;
    else        bank_full <= (bank_full & ~clr_mask) | set_mask;
  end
endmodule

// File: doc/s2_window_streamer.md
Name: s2_window_streamer

Overview:
- Receives the pooled S2 feature map from the C1 max-pooling stage: 6 channels, 14x14, 8-bit, raster order, one pixel per beat, no backpressure.
- Stores each frame in one of two ping-pong frame banks.
- Replays each stored frame to the C3 convolution engine as 5x5 windows, one window pixel (all channels) per beat, under valid/ready handshake.
- The next frame can be written to one bank while the other bank streams.

Parameters:
- IN_W, 14, input map width
- IN_H, 14, input map height
- K, 5, window size; OUT_W=IN_W-K+1 (10), OUT_H=IN_H-K+1 (10)
- CH, 6, channels
- DW, 8, bits per channel pixel

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  input pixel valid, from pooling stage
- in_data  in  CH*DW (48)  packed channels; ch0 in [7:0], ch5 in [47:40]
- win_valid  out  1  output beat valid
- win_ready  in  1  consumer accepts beat when win_valid&&win_ready
- win_data  out  CH*DW  window pixel, same packing as in_data
- win_first  out  1  beat is first of a window (ky=0,kx=0)
- win_last  out  1  beat is last of a window (ky=K-1,kx=K-1)
- win_frame_last  out  1  last beat of last window of the frame
- win_oy  out  4  output row of current window (0..OUT_H-1)
- win_ox  out  4  output column of current window (0..OUT_W-1)
- bank_full  out  2  per-bank frame-complete flags
- overflow  out  1  sticky: input beat dropped

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs go to 0: win_valid, win_data, win_first, win_last, win_frame_last, win_oy, win_ox, bank_full, overflow.
  - Write pointer, read pointer, write count and window counters go to 0.
  - Partial or stored frames are discarded; bank contents do not need clearing.
- Write side:
  - wr_bank starts at 0; wr_cnt counts 0..IN_W*IN_H-1 (0..195).
  - Each in_valid with bank_full[wr_bank]=0 writes mem[wr_bank][wr_cnt] and increments wr_cnt.
  - On the beat with wr_cnt=195: set bank_full[wr_bank], wr_cnt<=0, toggle wr_bank.
  - If in_valid arrives while bank_full[wr_bank]=1, the beat is dropped, overflow<=1 (sticky until reset), and wr_cnt is unchanged.
- Read FSM states:
  - IDLE: go to STREAM when bank_full[rd_bank]=1.
  - STREAM: go to DRAIN when the final beat is loaded into the output register.
  - DRAIN: wait until the final beat is accepted, then clear bank_full[rd_bank], toggle rd_bank, go to IDLE.
- Beat ordering:
  - Window counters nest, outermost to innermost: oy, ox, ky, kx.
  - Read address = (oy+ky)*IN_W + (ox+kx).
  - Beats per window = 25; windows per frame = 100; beats per frame = 2500.
- Output register:
  - Loads the next beat in STREAM when !win_valid || win_ready; the counters advance on each load.
  - While win_valid && !win_ready, every win_* output holds stable.
  - In IDLE and DRAIN: win_valid<=0 when win_ready is sampled high; no new loads occur.
  - win_first, win_last, win_frame_last, win_oy and win_ox are registered with win_data.
- Latency:
  - Edge E0 samples the 196th input beat and sets bank_full.
  - E1: FSM moves IDLE->STREAM.
  - E2: first beat presented (win_valid=1).
  - With win_ready held high, beats are back-to-back: 2500 consecutive cycles, no bubbles inside a frame.
- Frame-to-frame gap:
  - After the last beat is accepted, bank_full clears on that edge.
  - If the other bank is already full, its first beat appears 2 edges later (DRAIN->IDLE->STREAM).
- Simultaneous events:
  - Write completion and read release on the same edge are independent. Each bank's flag is set only by the writer and cleared only by the reader.
  - The writer can never target the bank being read, because that bank is full.
- Reset mid-stream: all state is abandoned, win_valid=0 after the reset edge, and the next frame writes bank 0.

Test Plan:
- Single frame, pixel p ch c = (p+c)&8'hFF, win_ready=1:
  - First 25 beats use addresses 0..4, 14..18, 28..32, 42..46, 56..60.
  - 2500 beats total; win_first on beats 0,25,...; win_last on beats 24,49,...
  - Beat 2499 has win_frame_last=1, win_oy=9, win_ox=9, ch0 data=195.
- Latency: last input on edge E0 -> win_valid=1 exactly after E2; bank_full=2'b01 after E0, 2'b00 after the final acceptance.
- Random win_ready (50%):
  - Beat sequence identical to the ready=1 run.
  - win_data and flags stable on every valid&&!ready cycle; no beat lost or duplicated.
- Two back-to-back frames (392 consecutive in_valid), win_ready=1:
  - Frame 2 goes to bank 1 while frame 1 streams.
  - Frame 2's first beat appears 2 cycles after frame 1's final acceptance; overflow stays 0.
- Three back-to-back frames, win_ready=0:
  - bank_full=2'b11, overflow=1, frame 3 dropped.
  - Then win_ready=1: exactly frames 1 and 2 (5000 beats) emitted, overflow remains 1.
- Reset mid-stream:
  - Assert rst_n=0 at beat 1000 -> win_valid=0, bank_full=0, overflow=0.
  - A new frame then streams from window (0,0), address 0.
